// File: rtl/floor_to_int.sv
// FP32 -> signed int32 converter for the floor+ftoi path: truncates toward zero and saturates
// out-of-range, infinite and NaN operands with an overflow flag. Two register stages plus a global stall.
module floor_to_int #(
    parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] op,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        ovf
);

    localparam logic [7:0]  ExpBias    = 8'd127;
    localparam logic [7:0]  ExpMantTop = 8'd150;  // E == 23: mantissa already integral
    localparam logic [7:0]  ExpMaxShl  = 8'd157;  // E == 30
    localparam logic [7:0]  ExpIntMin  = 8'd158;  // E == 31
    localparam logic [31:0] IntMin     = 32'h8000_0000;
    localparam logic [31:0] IntMax     = 32'h7FFF_FFFF;

    // Operand fields
    logic        op_sig;
    logic [7:0]  op_exp;
    logic [22:0] op_fra;
    logic [31:0] op_mant;
    logic [4:0]  shr_amt;
    logic [2:0]  shl_amt;

    // Stage 1 next-state and registers
    logic        s1_valid_q;
    logic        s1_sig_q;
    logic [31:0] s1_mag_d, s1_mag_q;
    logic        s1_sat_d, s1_sat_q;
    logic        s1_nan_d, s1_nan_q;

    // Stage 2 next-state
    logic [31:0] result_d;
    logic        ovf_d;

    always_comb begin
        op_sig   = op[31];
        op_exp   = op[30:23];
        op_fra   = op[22:0];
        op_mant  = {8'b0, 1'b1, op_fra};
        shr_amt  = 5'(ExpMantTop - op_exp);
        shl_amt  = 3'(op_exp - ExpMantTop);
        s1_mag_d = '0;
        s1_sat_d = 1'b0;
        s1_nan_d = 1'b0;

        if (op_exp == 8'hFF) begin
            s1_sat_d = 1'b1;
            s1_nan_d = (op_fra != '0);
        end else if (op_exp < ExpBias) begin
            // |x| < 1, including zero and denormals
            s1_mag_d = '0;
        end else if (op_exp <= ExpMantTop) begin
            s1_mag_d = op_mant >> shr_amt;
        end else if (op_exp <= ExpMaxShl) begin
            s1_mag_d = op_mant << shl_amt;
        end else if (op_exp == ExpIntMin) begin
            // Only exactly -2^31 is representable at this exponent
            if (op_sig && (op_fra == '0)) begin
                s1_mag_d = IntMin;
            end else begin
                s1_sat_d = 1'b1;
            end
        end else begin
            s1_sat_d = 1'b1;
        end
    end

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        if (s1_nan_q) begin
            result_d = NAN_RESULT;
            ovf_d    = 1'b1;
        end else if (s1_sat_q) begin
            result_d = s1_sig_q ? IntMin : IntMax;
            ovf_d    = 1'b1;
        end else begin
            // -2^31 magnitude negates onto itself, which is the correct result
            result_d = s1_sig_q ? (~s1_mag_q + 32'd1) : s1_mag_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sig_q   <= 1'b0;
            s1_mag_q   <= '0;
            s1_sat_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s1_sig_q   <= op_sig;
            s1_mag_q   <= s1_mag_d;
            s1_sat_q   <= s1_sat_d;
            s1_nan_q   <= s1_nan_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid_q;
            result    <= result_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_floor_to_int.sv
// Scoreboard bench for floor_to_int: directed FP32 vectors, bubbles, stall hold and mid-stream reset.
module tb_floor_to_int;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    localparam int NVEC = 23;
    localparam logic [31:0] VOP [NVEC] = '{
        32'h40A00000, 32'hC0400000, 32'h3FC00000, 32'h80000000, 32'hCF000000, 32'h4F000000,
        32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h3F000000, 32'hBFC00000, 32'h4E800000,
        32'h4EFFFFFF, 32'hCF000001, 32'h4B800001, 32'h4AFFFFFF, 32'h00000001, 32'hFF800001,
        32'h501502F9, 32'hC2F78000, 32'hBF400000, 32'h3F800000, 32'hCEFFFFFF};
    localparam logic [31:0] VRES [NVEC] = '{
        32'h00000005, 32'hFFFFFFFD, 32'h00000001, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
        32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h40000000,
        32'h7FFFFF80, 32'h80000000, 32'h01000002, 32'h007FFFFF, 32'h00000000, 32'h7FFFFFFF,
        32'h7FFFFFFF, 32'hFFFFFF85, 32'h00000000, 32'h00000001, 32'h80000080};
    localparam logic VOVF [NVEC] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] op = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] result;
    logic        ovf;

    exp_t sb_q[$];
    exp_t cur_exp = '0;
    exp_t held = '0;
    logic acc1 = 1'b0, acc2 = 1'b0, last_stall = 1'b0;
    int   total = 0;
    int   bad = 0;

    floor_to_int #(.NAN_RESULT(32'h7FFF_FFFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .op       (op),
        .stall    (stall),
        .out_valid(out_valid),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got_r, input logic got_o,
                       input logic [31:0] want_r, input logic want_o);
        total++;
        if (got_r !== want_r || got_o !== want_o) begin
            bad++;
            $display("FAIL %s: got result=%h ovf=%b, want result=%h ovf=%b", name, got_r, got_o,
                     want_r, want_o);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] v, input logic [31:0] r, input logic o);
        in_valid = 1'b1;
        op       = v;
        cur_exp  = '{res: r, ovf: o};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Acceptance tracker: expected results enter the queue on every accepting edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc1       <= 1'b0;
            acc2       <= 1'b0;
            last_stall <= 1'b0;
            sb_q.delete();
        end else begin
            last_stall <= stall;
            if (!stall) begin
                acc1 <= in_valid;
                acc2 <= acc1;
                if (in_valid) sb_q.push_back(cur_exp);
            end
        end
    end

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk_bit("out_valid", out_valid, acc2);
            if (acc2) begin
                if (last_stall) begin
                    chk("stall_hold", result, ovf, held.res, held.ovf);
                end else if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got result=%h with empty scoreboard", result);
                end else begin
                    held = sb_q.pop_front();
                    chk("result", result, ovf, held.res, held.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_state", result, ovf, 32'h0, 1'b0);
        chk_bit("reset_valid", out_valid, 1'b0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        for (int i = 0; i < NVEC; i++) send(VOP[i], VRES[i], VOVF[i]);
        repeat (3) @(posedge clk);
        #1;

        // Same vectors with a bubble after each
        for (int i = NVEC - 1; i >= 0; i--) begin
            send(VOP[i], VRES[i], VOVF[i]);
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;

        // Stall for 3 cycles after the second accept; the op held on the bus must be ignored
        send(32'h3F800000, 32'd1, 1'b0);
        send(32'h40000000, 32'd2, 1'b0);
        stall    = 1'b1;
        in_valid = 1'b1;
        op       = 32'h40A00000;
        repeat (3) @(posedge clk);
        #1;
        stall    = 1'b0;
        in_valid = 1'b0;
        send(32'h40400000, 32'd3, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Mid-stream asynchronous reset discards in-flight ops
        for (int i = 0; i < 4; i++) send(VOP[i], VRES[i], VOVF[i]);
        reset = 1'b1;
        #1;
        chk("async_reset", result, ovf, 32'h0, 1'b0);
        chk_bit("async_reset_valid", out_valid, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        send(VOP[4], VRES[4], VOVF[4]);
        send(VOP[6], VRES[6], VOVF[6]);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
